// File: rtl/i2c_master_arbiter.sv
// Round-robin arbiter sharing one I2C master between NREQ requesters.
// Latches the winner's payload and sequences Start/RW/Set_pointer/Return, including pointer-set + repeated-start reads.
module i2c_master_arbiter #(
  parameter int          NREQ    = 2,
  parameter logic [15:0] TIMEOUT = 16'd50000
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic [NREQ-1:0]      Req,
  input  logic [NREQ-1:0]      Req_rw,
  input  logic [NREQ*8-1:0]    Req_ptr,
  input  logic [NREQ*16-1:0]   Req_wdata,
  output logic [NREQ-1:0]      Gnt,
  output logic [NREQ-1:0]      Done,
  output logic [NREQ-1:0]      Err,
  output logic [15:0]          Rdata,
  output logic                 Busy,
  output logic                 M_Start,
  output logic                 M_RW,
  output logic [7:0]           M_Pointer,
  output logic                 M_Set_pointer,
  output logic                 M_Return,
  output logic [15:0]          M_Wdata,
  input  logic                 M_Ready,
  input  logic                 M_Repeat,
  input  logic                 M_Data_valid,
  input  logic                 M_Error,
  input  logic [15:0]          M_Rdata
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [2:0] {IDLE, ARB, LAUNCH, WAIT_PTR, RESTART, WAIT_DONE, COMPLETE} state_t;

  state_t          state, state_nxt;
  logic [IW-1:0]   rr, win, idx;
  logic            found;
  logic [NREQ-1:0] gnt_q, gnt_arb;
  logic            sel_rw;
  logic [7:0]      sel_ptr;
  logic [15:0]     sel_wdata;
  logic            rw_q, err_q, err_nxt, dv_seen;
  logic [7:0]      ptr_q;
  logic [15:0]     wdata_q;
  logic [15:0]     tmr;
  logic            tmo;

  // First set request at or after the round-robin pointer, wrapping at NREQ.
  always_comb begin : pick
    logic [IW:0] s;
    found = 1'b0;
    win   = '0;
    s     = '0;
    for (int i = 0; i < NREQ; i++) begin
      s = {1'b0, rr} + (IW+1)'(i);
      if (s >= (IW+1)'(NREQ)) s = s - (IW+1)'(NREQ);
      if (!found && Req[s[IW-1:0]]) begin
        found = 1'b1;
        win   = s[IW-1:0];
      end
    end
  end

  always_comb begin
    sel_rw    = 1'b0;
    sel_ptr   = '0;
    sel_wdata = '0;
    gnt_arb   = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (found && win == IW'(i)) begin
        sel_rw     = Req_rw[i];
        sel_ptr    = Req_ptr[i*8 +: 8];
        sel_wdata  = Req_wdata[i*16 +: 16];
        gnt_arb[i] = 1'b1;
      end
    end
  end

  assign tmo = (tmr == '0);

  always_comb begin
    state_nxt = state;
    err_nxt   = err_q;
    case (state)
      IDLE:     if (|Req && M_Ready) state_nxt = ARB;
      ARB: begin
        err_nxt   = 1'b0;
        state_nxt = found ? LAUNCH : IDLE;
      end
      LAUNCH:   if (!M_Ready) state_nxt = rw_q ? WAIT_PTR : WAIT_DONE;
      WAIT_PTR: begin
        if (M_Repeat) state_nxt = RESTART;
        else if (M_Ready) begin
          state_nxt = COMPLETE;
          err_nxt   = 1'b1;
        end
      end
      RESTART:  if (!M_Repeat) state_nxt = WAIT_DONE;
      WAIT_DONE: begin
        if (M_Error) err_nxt = 1'b1;
        if (M_Ready) begin
          state_nxt = COMPLETE;
          if (rw_q && !dv_seen && !M_Data_valid) err_nxt = 1'b1;
        end
      end
      COMPLETE: state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
    // The watchdog overrides whatever the master is doing.
    if ((state == LAUNCH || state == WAIT_PTR || state == RESTART || state == WAIT_DONE) && tmo) begin
      state_nxt = COMPLETE;
      err_nxt   = 1'b1;
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state   <= IDLE;
      rr      <= '0;
      idx     <= '0;
      gnt_q   <= '0;
      rw_q    <= 1'b0;
      ptr_q   <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
      dv_seen <= 1'b0;
      tmr     <= '0;
      Rdata   <= '0;
    end else begin
      state <= state_nxt;
      err_q <= err_nxt;
      case (state)
        ARB: begin
          gnt_q   <= gnt_arb;
          idx     <= win;
          rw_q    <= sel_rw;
          ptr_q   <= sel_ptr;
          wdata_q <= sel_wdata;
          dv_seen <= 1'b0;
          tmr     <= TIMEOUT - 16'd1;
        end
        LAUNCH, WAIT_PTR, RESTART, WAIT_DONE: if (!tmo) tmr <= tmr - 16'd1;
        COMPLETE: begin
          gnt_q <= '0;
          rr    <= (idx == IW'(NREQ - 1)) ? '0 : idx + 1'b1;
        end
        default: ;
      endcase
      if (state == WAIT_DONE && M_Data_valid) begin
        Rdata   <= M_Rdata;
        dv_seen <= 1'b1;
      end
    end
  end

  assign Busy          = (state != IDLE);
  assign Gnt           = (state == ARB) ? gnt_arb : gnt_q;
  assign Done          = (state == COMPLETE) ? gnt_q : '0;
  assign Err           = (state == COMPLETE && err_q) ? gnt_q : '0;
  assign M_Start       = (state == LAUNCH);
  assign M_Set_pointer = (state == LAUNCH) && rw_q;
  assign M_RW          = (state == RESTART);
  assign M_Return      = (state == RESTART);
  assign M_Pointer     = ptr_q;
  assign M_Wdata       = wdata_q;
endmodule

// File: tb/tb_i2c_master_arbiter.sv
// Directed bench for i2c_master_arbiter: a transaction table driven through a hand-sequenced
// master model, plus timeout and asynchronous-reset sequences.
module tb_i2c_master_arbiter;
  localparam int NREQ = 2;

  logic              Clk, Rst;
  logic [NREQ-1:0]   Req, Req_rw;
  logic [NREQ*8-1:0] Req_ptr;
  logic [NREQ*16-1:0] Req_wdata;
  logic [NREQ-1:0]   Gnt, Done, Err;
  logic [15:0]       Rdata;
  logic              Busy, M_Start, M_RW, M_Set_pointer, M_Return;
  logic [7:0]        M_Pointer;
  logic [15:0]       M_Wdata;
  logic              M_Ready, M_Repeat, M_Data_valid, M_Error;
  logic [15:0]       M_Rdata;

  i2c_master_arbiter #(.NREQ(NREQ), .TIMEOUT(16'd100)) dut (
    .Clk(Clk), .Rst(Rst), .Req(Req), .Req_rw(Req_rw), .Req_ptr(Req_ptr), .Req_wdata(Req_wdata),
    .Gnt(Gnt), .Done(Done), .Err(Err), .Rdata(Rdata), .Busy(Busy),
    .M_Start(M_Start), .M_RW(M_RW), .M_Pointer(M_Pointer), .M_Set_pointer(M_Set_pointer),
    .M_Return(M_Return), .M_Wdata(M_Wdata), .M_Ready(M_Ready), .M_Repeat(M_Repeat),
    .M_Data_valid(M_Data_valid), .M_Error(M_Error), .M_Rdata(M_Rdata)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // mode: 0 clean, 1 pointer/address NACK, 2 M_Error with M_Ready, 3 read with no data byte
  typedef struct {
    logic [1:0]  req;
    logic [1:0]  rw;
    logic [7:0]  ptr0;
    logic [7:0]  ptr1;
    logic [15:0] wd0;
    logic [15:0] wd1;
    int          mode;
    logic [15:0] sdata;
    logic [1:0]  exp_gnt;
    logic        exp_err;
  } vec_t;

  int checks = 0;
  int errors = 0;
  int done_count = 0;
  int gnt_multi = 0;

  always @(negedge Clk) begin
    if (Done != 0) done_count++;
    if ($countones(Gnt) > 1) gnt_multi++;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, output int lat);
    int n;
    logic rd;
    logic [7:0] eptr;
    logic [15:0] ewd;
    Req_rw = v.rw; Req_ptr = {v.ptr1, v.ptr0}; Req_wdata = {v.wd1, v.wd0}; Req = v.req;
    M_Ready = 1'b1; M_Repeat = 1'b0; M_Data_valid = 1'b0; M_Error = 1'b0;
    rd   = |(v.rw & v.exp_gnt);
    eptr = v.exp_gnt[1] ? v.ptr1 : v.ptr0;
    ewd  = v.exp_gnt[1] ? v.wd1 : v.wd0;
    n = 0;
    do begin @(negedge Clk); n++; end while (Gnt == 0 && n < 10);
    lat = n;
    check("gnt", Gnt, v.exp_gnt);
    if (Gnt == 0) return;
    @(negedge Clk);
    check("launch_start", M_Start, 1'b1);
    check("launch_rw", M_RW, 1'b0);
    check("launch_setptr", M_Set_pointer, rd);
    check("launch_ptr", M_Pointer, eptr);
    check("launch_wdata", M_Wdata, ewd);
    check("launch_busy", Busy, 1'b1);
    M_Ready = 1'b0;
    @(negedge Clk);
    check("start_dropped", M_Start, 1'b0);
    if (rd) begin
      if (v.mode == 1) begin
        M_Ready = 1'b1;
      end else begin
        M_Repeat = 1'b1;
        @(negedge Clk);
        check("restart_return", M_Return, 1'b1);
        check("restart_rw", M_RW, 1'b1);
        check("restart_setptr", M_Set_pointer, 1'b0);
        M_Repeat = 1'b0;
        @(negedge Clk);
        if (v.mode != 3) begin
          M_Data_valid = 1'b1; M_Rdata = v.sdata;
          @(negedge Clk);
          M_Data_valid = 1'b0; M_Rdata = 16'hDEAD;
        end
        M_Ready = 1'b1; M_Error = (v.mode == 2);
      end
    end else begin
      M_Ready = 1'b1; M_Error = (v.mode == 2);
    end
    n = 0;
    do begin @(negedge Clk); n++; end while (Done == 0 && n < 5);
    M_Error = 1'b0;
    check("done", Done, v.exp_gnt);
    check("err", Err, v.exp_err ? v.exp_gnt : 2'b00);
    if (rd && v.mode == 0) check("rdata", Rdata, v.sdata);
    @(negedge Clk);
    check("gnt_cleared", Gnt, 2'b00);
    check("done_single", Done, 2'b00);
  endtask

  vec_t vecs[11];
  vec_t tv;

  initial begin
    int lat, n, bad, dc;
    vecs[0]  = '{2'b01, 2'b00, 8'h02, 8'h00, 16'h4B00, 16'h0000, 0, 16'h0000, 2'b01, 1'b0};
    vecs[1]  = '{2'b10, 2'b10, 8'hAA, 8'h00, 16'h0000, 16'h0000, 0, 16'h1920, 2'b10, 1'b0};
    vecs[2]  = '{2'b11, 2'b10, 8'h11, 8'h22, 16'h1111, 16'h2222, 0, 16'h3344, 2'b01, 1'b0};
    vecs[3]  = '{2'b11, 2'b10, 8'h11, 8'h22, 16'h1111, 16'h2222, 0, 16'h3344, 2'b10, 1'b0};
    vecs[4]  = '{2'b11, 2'b10, 8'h13, 8'h24, 16'h1313, 16'h2424, 0, 16'h5566, 2'b01, 1'b0};
    vecs[5]  = '{2'b11, 2'b10, 8'h13, 8'h24, 16'h1313, 16'h2424, 0, 16'h5566, 2'b10, 1'b0};
    vecs[6]  = '{2'b01, 2'b01, 8'h40, 8'h00, 16'h0000, 16'h0000, 1, 16'h0000, 2'b01, 1'b1};
    vecs[7]  = '{2'b10, 2'b00, 8'h00, 8'h48, 16'h0000, 16'hBEEF, 2, 16'h0000, 2'b10, 1'b1};
    vecs[8]  = '{2'b11, 2'b11, 8'h50, 8'h51, 16'h0000, 16'h0000, 3, 16'h0000, 2'b01, 1'b1};
    vecs[9]  = '{2'b11, 2'b11, 8'h60, 8'h61, 16'h0000, 16'h0000, 2, 16'h7777, 2'b10, 1'b1};
    vecs[10] = '{2'b10, 2'b00, 8'h00, 8'h70, 16'h0000, 16'hCAFE, 0, 16'h0000, 2'b10, 1'b0};

    Rst = 1'b0; Req = '0; Req_rw = '0; Req_ptr = '0; Req_wdata = '0;
    M_Ready = 1'b1; M_Repeat = 1'b0; M_Data_valid = 1'b0; M_Error = 1'b0; M_Rdata = '0;
    #12;
    check("reset_outputs", {Gnt, Done, Err, Busy, M_Start, M_RW, M_Set_pointer, M_Return,
                            M_Pointer, M_Wdata, Rdata}, 64'd0);
    @(negedge Clk); Rst = 1'b1;
    @(negedge Clk);

    for (int i = 0; i < 11; i++) run_vec(vecs[i], lat);
    Req = '0;
    @(negedge Clk);

    // Slave stretches the transaction past the 100-cycle watchdog.
    Req_rw = '0; Req_ptr = '0; Req_wdata = '0; Req = 2'b01; M_Ready = 1'b1;
    n = 0;
    do begin @(negedge Clk); n++; end while (M_Start !== 1'b1 && n < 10);
    check("to_start", M_Start, 1'b1);
    M_Ready = 1'b0;
    n = 0;
    do begin @(negedge Clk); n++; end while (Done == 0 && n < 200);
    check("to_cycles", n, 100);
    check("to_done", Done, 2'b01);
    check("to_err", Err, 2'b01);
    bad = 0;
    repeat (20) begin @(negedge Clk); if (Gnt != 0) bad++; end
    check("to_hold_no_gnt", bad, 0);
    tv = '{2'b01, 2'b00, 8'h33, 8'h00, 16'h0033, 16'h0000, 0, 16'h0000, 2'b01, 1'b0};
    run_vec(tv, lat);
    Req = '0;
    @(negedge Clk);

    // Asynchronous reset in WAIT_DONE.
    Req_rw = '0; Req_ptr = {8'h00, 8'h9A}; Req_wdata = {16'h0000, 16'h1234}; Req = 2'b01; M_Ready = 1'b1;
    n = 0;
    do begin @(negedge Clk); n++; end while (Gnt == 0 && n < 10);
    @(negedge Clk);
    M_Ready = 1'b0;
    @(negedge Clk);
    check("rst_pre_busy", Busy, 1'b1);
    dc = done_count;
    #2 Rst = 1'b0;
    #1;
    check("rst_async", {Gnt, Done, Err, Busy, M_Start, M_RW, M_Set_pointer, M_Return,
                        M_Pointer, M_Wdata, Rdata}, 64'd0);
    Req = '0; M_Ready = 1'b1;
    @(negedge Clk); Rst = 1'b1;
    repeat (3) @(negedge Clk);
    check("rst_no_done", done_count, dc);
    tv = '{2'b11, 2'b00, 8'h05, 8'h06, 16'h0505, 16'h0606, 0, 16'h0000, 2'b01, 1'b0};
    run_vec(tv, lat);
    check("rst_latency", lat, 1);
    Req = '0;
    repeat (2) @(negedge Clk);

    check("done_total", done_count, 14);
    check("gnt_onehot", gnt_multi, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
